// File: rtl/beep_pkg.sv
// Shared definitions for the buzzer tone path: FSM encoding and period limits.
package beep_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int MIN_CYCLE  = 2;
    localparam int DUTY_W_DEF = 4;

endpackage

// File: rtl/beep_pwm.sv
// Square-wave buzzer driver: period and duty are captured only at period
// boundaries so the pin never glitches; periods shorter than two clocks mean silence.
module beep_pwm
    import beep_pkg::*;
#(
    parameter int CLK_FRE = 50,
    parameter int CNT_W   = 20,
    parameter int DUTY_W  = DUTY_W_DEF
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              en,
    input  logic [CNT_W-1:0]  cycle,
    input  logic [DUTY_W-1:0] duty,
    output logic              beep,
    output logic              period_start,
    output logic              busy
);

    if (CLK_FRE <= 0) begin : g_bad_clk_fre
        $error("beep_pwm: CLK_FRE must be positive");
    end

    // High time = floor(cycle * duty / 2^DUTY_W), full-width product then truncated.
    function automatic logic [CNT_W-1:0] calc_high(input logic [CNT_W-1:0]  c,
                                                   input logic [DUTY_W-1:0] d);
        calc_high = CNT_W'(({{DUTY_W{1'b0}}, c} * {{CNT_W{1'b0}}, d}) >> DUTY_W);
    endfunction

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   cycle_q, cycle_d;
    logic [CNT_W-1:0]   high_q, high_d;
    logic               beep_q, beep_d;
    logic               ps_q, ps_d;
    logic               busy_q, busy_d;
    logic               valid;

    assign valid = en && (cycle >= CNT_W'(MIN_CYCLE));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cycle_d = cycle_q;
        high_d  = high_q;
        beep_d  = 1'b0;
        ps_d    = 1'b0;
        busy_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (valid) begin
                    cycle_d = cycle;
                    high_d  = calc_high(cycle, duty);
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // busy_q still low marks the first RUN clock: present cnt=0 of the first period.
                if (!busy_q) begin
                    cnt_d = '0;
                end else if (cnt_q == cycle_q - CNT_W'(1)) begin
                    cnt_d = '0;
                    if (valid) begin
                        cycle_d = cycle;
                        high_d  = calc_high(cycle, duty);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end

                if (state_d == ST_RUN) begin
                    busy_d = 1'b1;
                    ps_d   = (cnt_d == '0);
                    beep_d = (cnt_d < high_d);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            cycle_q <= '0;
            high_q  <= '0;
            beep_q  <= 1'b0;
            ps_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cycle_q <= cycle_d;
            high_q  <= high_d;
            beep_q  <= beep_d;
            ps_q    <= ps_d;
            busy_q  <= busy_d;
        end
    end

    assign beep         = beep_q;
    assign period_start = ps_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_beep_pwm.sv
// Bench for beep_pwm: stimulus queues expected periods (length, high clocks);
// a monitor measures each period the DUT produces and compares against the queue.
module tb_beep_pwm;

    localparam int CNT_W  = 20;
    localparam int DUTY_W = 4;

    logic              sys_clk   = 1'b0;
    logic              sys_rst_n = 1'b0;
    logic              en        = 1'b0;
    logic [CNT_W-1:0]  cycle     = '0;
    logic [DUTY_W-1:0] duty      = '0;
    logic              beep;
    logic              period_start;
    logic              busy;

    typedef struct packed {
        int len;
        int hi;
    } per_t;

    per_t exp_q[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    always #5 sys_clk = ~sys_clk;

    beep_pwm #(
        .CLK_FRE (50),
        .CNT_W   (CNT_W),
        .DUTY_W  (DUTY_W)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .en           (en),
        .cycle        (cycle),
        .duty         (duty),
        .beep         (beep),
        .period_start (period_start),
        .busy         (busy)
    );

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Reference: a tone of period c and duty code du is high for floor(c*du/16) clocks.
    function automatic per_t model_period(input int c, input int du);
        per_t p;
        p.len = c;
        p.hi  = (c * du) / 16;
        return p;
    endfunction

    // ---------------- monitor ----------------
    bit meas = 0;
    bit seen_low = 0;
    bit shape_ok = 1;
    bit prev_busy = 0;
    int m_len = 0;
    int m_hi = 0;

    task automatic finalize_period();
        per_t e;
        if (exp_q.size() == 0) begin
            check("unexpected_period", m_len, 0);
        end else begin
            e = exp_q.pop_front();
            check("period_len", m_len, e.len);
            check("period_high", m_hi, e.hi);
            check("period_shape", int'(shape_ok), 1);
        end
    endtask

    always @(negedge sys_clk) begin
        if (!sys_rst_n) begin
            meas      = 0;
            prev_busy = 0;
        end else begin
            if (meas && (period_start || !busy)) begin
                finalize_period();
                meas = 0;
            end
            if (period_start) begin
                meas     = 1;
                m_len    = 0;
                m_hi     = 0;
                seen_low = 0;
                shape_ok = 1;
            end
            if (meas) begin
                m_len++;
                if (beep) begin
                    m_hi++;
                    if (seen_low) shape_ok = 0;
                end else begin
                    seen_low = 1;
                end
            end
            if (prev_busy && !busy) check("stop_beep", int'(beep), 0);
            prev_busy = busy;
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_ps(input string what, output int k);
        k = 0;
        do begin
            @(negedge sys_clk);
            k++;
        end while (period_start !== 1'b1 && k < 25000);
        if (period_start !== 1'b1) check({what, "_timeout"}, k, -1);
    endtask

    // Plays n periods of (c, du); returns in the clock with cnt=d of the last one.
    task automatic run_segment(input int c, input int du, input int n, input int d_in,
                               output int k_first, output int d_used);
        int k;
        en    = 1'b1;
        cycle = CNT_W'(c);
        duty  = DUTY_W'(du);
        for (int i = 0; i < n; i++) exp_q.push_back(model_period(c, du));
        k_first = 0;
        for (int i = 0; i < n; i++) begin
            wait_ps("seg_ps", k);
            if (i == 0) k_first = k;
        end
        d_used = (d_in < 0) ? int'($urandom_range(c - 1, 0)) : d_in;
        repeat (d_used) @(negedge sys_clk);
    endtask

    task automatic stop_and_check(input string name, input int exp_k);
        int  k;
        bit  quiet;
        en = 1'b0;
        k  = 0;
        do begin
            @(negedge sys_clk);
            k++;
        end while (busy === 1'b1 && k < 25000);
        check(name, k, exp_k);
        quiet = 1;
        repeat (20) begin
            @(negedge sys_clk);
            if (period_start !== 1'b0 || busy !== 1'b0 || beep !== 1'b0) quiet = 0;
        end
        check({name, "_quiet"}, int'(quiet), 1);
    endtask

    task automatic silence(input string name, input int c, input int du, input logic e, input int n);
        bit quiet;
        en    = e;
        cycle = CNT_W'(c);
        duty  = DUTY_W'(du);
        quiet = 1;
        repeat (n) begin
            @(negedge sys_clk);
            if (period_start !== 1'b0 || busy !== 1'b0 || beep !== 1'b0) quiet = 0;
        end
        check(name, int'(quiet), 1);
    endtask

    initial begin
        int k1;
        int d;
        int c;
        int du;

        repeat (3) @(negedge sys_clk);
        check("reset_beep", int'(beep), 0);
        check("reset_ps", int'(period_start), 0);
        check("reset_busy", int'(busy), 0);
        sys_rst_n = 1'b1;

        silence("silence_cycle0", 0, 8, 1'b1, 50);
        silence("silence_cycle1", 1, 8, 1'b1, 50);
        silence("silence_en0", 10, 8, 1'b0, 20);

        run_segment(10, 8, 4, 3, k1, d);
        check("start_latency", k1, 2);
        run_segment(6, 4, 2, -1, k1, d);
        run_segment(10, 8, 1, 2, k1, d);
        stop_and_check("stop_latency", 8);

        run_segment(10, 0, 3, -1, k1, d);
        check("start_latency_duty0", k1, 2);
        run_segment(2, 15, 3, -1, k1, d);
        run_segment(3, 5, 2, -1, k1, d);
        run_segment(16, 15, 2, -1, k1, d);
        run_segment(19157, 8, 1, -1, k1, d);
        stop_and_check("stop_long", 19157 - d);

        run_segment(10, 8, 2, 4, k1, d);
        check("beep_before_reset", int'(beep), 1);
        #1 sys_rst_n = 1'b0;
        #1;
        check("async_beep", int'(beep), 0);
        check("async_busy", int'(busy), 0);
        check("async_ps", int'(period_start), 0);
        exp_q.delete();
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        run_segment(10, 8, 2, -1, k1, d);
        check("restart_latency", k1, 2);

        c = 10;
        for (int i = 0; i < 8; i++) begin
            c  = int'($urandom_range(40, 2));
            du = int'($urandom_range(15, 0));
            run_segment(c, du, int'($urandom_range(3, 1)), -1, k1, d);
        end
        stop_and_check("stop_random", c - d);

        repeat (5) @(negedge sys_clk);
        check("queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
